// File: rtl/atk16_sram_pkg.sv
// atk16_sram_pkg: shared types and constants for the SRAM arbiter.
// Holds the access-sequence state enum, master indices and default widths.
package atk16_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_t;

  localparam logic M_CPU   = 1'b0;
  localparam logic M_FETCH = 1'b1;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: combinational 2-way round-robin grant.
// Ports: i_req[1:0], i_last, i_en in; o_gnt (master index), o_vld out.
module sram_rr_arb2
  import atk16_sram_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_en,
  output logic       o_gnt,
  output logic       o_vld
);

  // On a tie the master that did not win last time goes next.
  always_comb begin
    o_gnt = M_CPU;
    if (i_req == 2'b11)
      o_gnt = ~i_last;
    else if (i_req[1])
      o_gnt = M_FETCH;
  end

  assign o_vld = i_en & (|i_req);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between a r/w master and a read master.
// Ports: clk, rst, m0_*/m1_* master side, sram_* registered pad side.
module sram_arbiter
  import atk16_sram_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(STROBE_CYCLES - 1);

  state_t            r_state;
  logic              r_last;
  logic              r_gnt;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cs_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq_o;
  logic              r_dq_oe;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  logic       w_done;
  logic       w_en;
  logic [1:0] w_req;
  logic       w_gnt;
  logic       w_vld;
  logic       w_wr;

  assign w_done = (r_state == DONE);
  assign w_en   = (r_state == IDLE) | w_done;

  // The master finishing this cycle cannot be re-granted straight away.
  assign w_req[0] = m0_req & ~(w_done & (r_gnt == M_CPU));
  assign w_req[1] = m1_req & ~(w_done & (r_gnt == M_FETCH));

  // Master 1 is read-only.
  assign w_wr = (w_gnt == M_CPU) & m0_we;

  sram_rr_arb2 u_arb (
    .i_req  (w_req),
    .i_last (r_last),
    .i_en   (w_en),
    .o_gnt  (w_gnt),
    .o_vld  (w_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= M_FETCH;
      r_gnt   <= M_CPU;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_cs_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_addr  <= '0;
      r_dq_o  <= '0;
      r_dq_oe <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          r_oe_n <= 1'b1;
          r_we_n <= 1'b1;
          if (w_vld) begin
            r_state <= SETUP;
            r_gnt   <= w_gnt;
            r_last  <= w_gnt;
            r_we    <= w_wr;
            r_cs_n  <= 1'b0;
            r_dq_oe <= w_wr;
            r_addr  <= (w_gnt == M_FETCH) ? m1_addr : m0_addr;
            if (w_wr)
              r_dq_o <= m0_wdata;
          end else begin
            r_state <= IDLE;
            r_cs_n  <= 1'b1;
            r_dq_oe <= 1'b0;
          end
        end
        SETUP: begin
          r_state <= STROBE;
          r_cnt   <= CNT_LOAD;
          if (r_we)
            r_we_n <= 1'b0;
          else
            r_oe_n <= 1'b0;
        end
        STROBE: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            if (r_gnt == M_FETCH)
              r_ack1 <= 1'b1;
            else
              r_ack0 <= 1'b1;
            if (!r_we) begin
              if (r_gnt == M_FETCH)
                r_rd1 <= sram_dq_i;
              else
                r_rd0 <= sram_dq_i;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign m0_rdata   = r_rd0;
  assign m0_ack     = r_ack0;
  assign m1_rdata   = r_rd1;
  assign m1_ack     = r_ack1;
  assign sram_cs_n  = r_cs_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_addr  = r_addr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus against a transaction-timeline model.
// Drives both masters, emulates the SRAM array, checks every cycle.
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int SC = 2;
  localparam int L  = SC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req = 1'b0;
  logic          m0_we = 1'b0;
  logic          m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0;

  logic [DW-1:0] m0_rdata, m1_rdata, dq_o, dq_i;
  logic          m0_ack, m1_ack, cs_n, oe_n, we_n, dq_oe;
  logic [AW-1:0] addr;

  logic [DW-1:0] a_rd0, a_rd1, a_dqo, b_rd0, b_rd1, b_dqo;
  logic          a_ack0, a_ack1, a_cs, a_oe, a_we, a_dqoe;
  logic          b_ack0, b_ack1, b_cs, b_oe, b_we, b_dqoe;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] alt_dq = 16'hC0DE;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .sram_cs_n(cs_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_addr(addr), .sram_dq_o(dq_o), .sram_dq_oe(dq_oe),
    .sram_dq_i(dq_i)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(a_rd0), .m0_ack(a_ack0),
    .m1_req(m1_req), .m1_addr(m1_addr),
    .m1_rdata(a_rd1), .m1_ack(a_ack1),
    .sram_cs_n(a_cs), .sram_oe_n(a_oe), .sram_we_n(a_we),
    .sram_addr(a_addr), .sram_dq_o(a_dqo), .sram_dq_oe(a_dqoe),
    .sram_dq_i(alt_dq)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(15)) u15 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(b_rd0), .m0_ack(b_ack0),
    .m1_req(m1_req), .m1_addr(m1_addr),
    .m1_rdata(b_rd1), .m1_ack(b_ack1),
    .sram_cs_n(b_cs), .sram_oe_n(b_oe), .sram_we_n(b_we),
    .sram_addr(b_addr), .sram_dq_o(b_dqo), .sram_dq_oe(b_dqoe),
    .sram_dq_i(alt_dq)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // SRAM array behind the pads
  function automatic logic [15:0] init_val(input logic [17:0] a);
    if (a == 18'h00123) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(18'(i));
  assign dq_i = mem[addr];
  always @(posedge clk)
    if (!cs_n && !we_n && dq_oe) mem[addr] = dq_o;

  // Model: pos is the cycle index inside the current access
  // (0 idle, 1 setup, 2..SC+1 strobe, L done).
  int            pos = 0;
  bit            mst, mwe, last_m, mvalid = 0;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic [DW-1:0] mrd [2];
  logic [DW-1:0] mw [int];

  always @(posedge clk) begin : model
    bit r0, r1, pick;
    if (rst) begin
      pos = 0; last_m = 1; mst = 0; mwe = 0;
      maddr = '0; mdata = '0; mrd[0] = '0; mrd[1] = '0;
      mvalid = 1;
    end else begin
      if (pos == SC + 1) begin
        if (mwe) mw[int'(maddr)] = mdata;
        else mrd[mst] = mw.exists(int'(maddr)) ?
                        mw[int'(maddr)] : init_val(maddr);
      end
      if (pos == 0 || pos == L) begin
        r0 = m0_req && !(pos == L && mst == 0);
        r1 = m1_req && !(pos == L && mst == 1);
        if (r0 || r1) begin
          pick = (r0 && r1) ? !last_m : r1;
          last_m = pick; mst = pick; pos = 1;
          maddr = pick ? m1_addr : m0_addr;
          mwe = !pick && m0_we;
          if (mwe) mdata = m0_wdata;
        end else pos = 0;
      end else pos++;
    end
  end

  always @(negedge clk) begin : compare
    bit stb;
    if (mvalid) begin
      stb = (pos >= 2 && pos <= SC + 1);
      chk("cs_n", 32'(cs_n), 32'(pos == 0));
      chk("oe_n", 32'(oe_n), 32'(!(stb && !mwe)));
      chk("we_n", 32'(we_n), 32'(!(stb && mwe)));
      chk("dq_oe", 32'(dq_oe), 32'(pos != 0 && mwe));
      chk("addr", 32'(addr), 32'(maddr));
      if (pos != 0 && mwe) chk("dq_o", 32'(dq_o), 32'(mdata));
      chk("m0_ack", 32'(m0_ack), 32'(pos == L && mst == 0));
      chk("m1_ack", 32'(m1_ack), 32'(pos == L && mst == 1));
      chk("m0_rdata", 32'(m0_rdata), 32'(mrd[0]));
      chk("m1_rdata", 32'(m1_rdata), 32'(mrd[1]));
      chk("oe_vs_drive", 32'(dq_oe && !oe_n), 32'(0));
      chk("we_without_cs", 32'(!we_n && cs_n), 32'(0));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // One access: request sampled once, then released.
  task automatic access(input bit m, input bit we, input logic [17:0] a,
                        input logic [15:0] d, output int lat,
                        output int oel, output int wel, output int oec);
    lat = -1; oel = 0; wel = 0; oec = 0;
    if (m) begin m1_req = 1; m1_addr = a; end
    else begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) begin m0_req = 0; m1_req = 0; end
      oel += int'(!oe_n); wel += int'(!we_n); oec += int'(dq_oe);
      if (m ? m1_ack : m0_ack) begin lat = k; break; end
    end
    step();
  endtask

  initial begin : stim
    int lat, oel, wel, oec, n1, csh, la, lb, oa, ob;
    int am[$];
    int at[$];
    int exp_m[4];
    int exp_t[4];
    exp_m = '{0, 1, 0, 1};
    exp_t = '{4, 8, 12, 16};

    repeat (3) step();
    chk("rst_cs_n", 32'(cs_n), 32'(1));
    chk("rst_oe_n", 32'(oe_n), 32'(1));
    chk("rst_we_n", 32'(we_n), 32'(1));
    chk("rst_addr", 32'(addr), 32'(0));
    chk("rst_dq_o", 32'(dq_o), 32'(0));
    chk("rst_dq_oe", 32'(dq_oe), 32'(0));
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'(0));
    chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'(0));
    rst = 0;
    step();

    access(0, 0, 18'h00123, 16'h0, lat, oel, wel, oec);
    chk("rd_lat", 32'(lat), 32'(4));
    chk("rd_oe_width", 32'(oel), 32'(2));
    chk("rd_we_width", 32'(wel), 32'(0));
    chk("rd_drive", 32'(oec), 32'(0));
    chk("rd_data", 32'(m0_rdata), 32'h0000BEEF);

    access(0, 1, 18'h3FFFF, 16'hA5A5, lat, oel, wel, oec);
    chk("wr_lat", 32'(lat), 32'(4));
    chk("wr_we_width", 32'(wel), 32'(2));
    chk("wr_oe_width", 32'(oel), 32'(0));
    chk("wr_drive_cycles", 32'(oec), 32'(4));
    chk("wr_keeps_rdata", 32'(m0_rdata), 32'h0000BEEF);
    access(0, 0, 18'h3FFFF, 16'h0, lat, oel, wel, oec);
    chk("rb_data", 32'(m0_rdata), 32'h0000A5A5);

    access(1, 0, 18'h00777, 16'h0, lat, oel, wel, oec);
    chk("m1_lat", 32'(lat), 32'(4));
    chk("m1_data", 32'(m1_rdata), 32'h00005D2D);
    chk("m0_data_held", 32'(m0_rdata), 32'h0000A5A5);

    // contention from reset; also shows DONE->SETUP with no idle gap
    rst = 1; m0_req = 1; m1_req = 1; m0_we = 0;
    m0_addr = 18'h00010; m1_addr = 18'h00020;
    step(); step(); rst = 0;
    csh = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (m0_ack) begin am.push_back(0); at.push_back(k); end
      if (m1_ack) begin am.push_back(1); at.push_back(k); end
      csh += int'(cs_n);
    end
    m0_req = 0; m1_req = 0;
    chk("cont_acks", 32'(am.size()), 32'(4));
    for (int i = 0; i < am.size() && i < 4; i++) begin
      chk("cont_order", 32'(am[i]), 32'(exp_m[i]));
      chk("cont_time", 32'(at[i]), 32'(exp_t[i]));
    end
    chk("cont_no_idle", 32'(csh), 32'(0));
    chk("cont_m0_data", 32'(m0_rdata), 32'h00005A4A);
    chk("cont_m1_data", 32'(m1_rdata), 32'h00005A7A);
    step(); step();

    // withdrawal while busy, then while idle
    m0_req = 1; m0_we = 0; m0_addr = 18'h00100; m1_addr = 18'h00200;
    n1 = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2) m1_req = 1;
      if (k == 3) m1_req = 0;
      if (m0_ack) m0_req = 0;
      n1 += int'(m1_ack);
    end
    chk("wd_no_ack", 32'(n1), 32'(0));
    access(1, 0, 18'h00200, 16'h0, lat, oel, wel, oec);
    chk("wd_idle_lat", 32'(lat), 32'(4));

    // reset in the middle of a write strobe
    m0_req = 1; m0_we = 1; m0_addr = 18'h0AAAA; m0_wdata = 16'h1357;
    step(); step();
    chk("mid_we_low", 32'(we_n), 32'(0));
    rst = 1; m0_req = 0;
    step();
    chk("mid_cs_n", 32'(cs_n), 32'(1));
    chk("mid_strobes", 32'({oe_n, we_n}), 32'(3));
    chk("mid_dq_oe", 32'(dq_oe), 32'(0));
    chk("mid_ack", 32'({m0_ack, m1_ack}), 32'(0));
    chk("mid_rdata", 32'({m0_rdata, m1_rdata}), 32'(0));
    rst = 0;
    n1 = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      n1 += int'(m0_ack) + int'(m1_ack);
    end
    chk("mid_no_late_ack", 32'(n1), 32'(0));

    // strobe width follows the parameter
    rst = 1; step(); step(); rst = 0; step();
    m0_req = 1; m0_we = 0; m0_addr = 18'h00123;
    la = -1; lb = -1; oa = 0; ob = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 1) m0_req = 0;
      oa += int'(!a_oe); ob += int'(!b_oe);
      if (a_ack0 && la < 0) la = k;
      if (b_ack0 && lb < 0) lb = k;
    end
    chk("sc1_width", 32'(oa), 32'(1));
    chk("sc15_width", 32'(ob), 32'(15));
    chk("sc1_lat", 32'(la), 32'(3));
    chk("sc15_lat", 32'(lb), 32'(17));
    chk("sc1_data", 32'(a_rd0), 32'h0000C0DE);
    chk("sc15_data", 32'(b_rd0), 32'h0000C0DE);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
